// File: rtl/cic_decimator.sv
// cic_decimator: run-time ratio CIC decimator for a 1-bit sigma-delta bitstream.
// Ports:
//   clk        - sample clock; one din bit per cycle
//   rst        - synchronous, active-high reset
//   en         - run enable; rising edge starts a conversion
//   dec_ratio  - decimation ratio R, latched (clamped to 2..RMAX) on IDLE->WARMUP
//   din        - modulator bit (0 or 1)
//   dout       - decimated sample, ACC_W bits zero-extended to OUT_W
//   dout_valid - one-cycle strobe marking a new dout
//   running    - high while in WARMUP or RUN
module cic_decimator #(
    parameter int unsigned ORDER     = 2,
    parameter int unsigned RMAX_LOG2 = 8,
    parameter int unsigned OUT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [RMAX_LOG2:0]   dec_ratio,
    input  logic                 din,
    output logic [OUT_W-1:0]     dout,
    output logic                 dout_valid,
    output logic                 running
);

    localparam int unsigned ACC_W  = ORDER * RMAX_LOG2 + 1;
    localparam int unsigned CNT_W  = RMAX_LOG2;
    localparam int unsigned R_W    = RMAX_LOG2 + 1;
    localparam int unsigned WCNT_W = $clog2(ORDER + 1);

    localparam logic [R_W-1:0] R_MIN = R_W'(2);
    localparam logic [R_W-1:0] R_MAX = R_W'(2 ** RMAX_LOG2);

    // Elaboration-time parameter sanity
    if (ORDER == 0 || ORDER > 4) begin : g_bad_order
        $error("cic_decimator: ORDER must be in 1..4");
    end
    if (ACC_W > OUT_W) begin : g_bad_out_w
        $error("cic_decimator: OUT_W too narrow for ACC_W");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [R_W-1:0]      r_q, r_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [ACC_W-1:0]    integ_q [ORDER];
    logic [ACC_W-1:0]    integ_d [ORDER];
    logic [ACC_W-1:0]    dly_q   [ORDER];
    logic [ACC_W-1:0]    dly_d   [ORDER];
    logic [OUT_W-1:0]    dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                running_q, running_d;

    logic [ACC_W-1:0]    comb_c [ORDER+1];
    logic                tick_c;

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign running    = running_q;

    // Comb chain; only meaningful on a tick, fed by the pre-update last integrator
    always_comb begin
        comb_c[0] = integ_q[ORDER-1];
        for (int k = 1; k <= ORDER; k++) begin
            comb_c[k] = comb_c[k-1] - dly_q[k-1];
        end
    end

    assign tick_c = (state_q != S_IDLE) && (cnt_q == CNT_W'(r_q - R_W'(1)));

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        cnt_d        = cnt_q;
        wcnt_d       = wcnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        for (int k = 0; k < ORDER; k++) begin
            integ_d[k] = integ_q[k];
            dly_d[k]   = dly_q[k];
        end

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_WARMUP;
                    if (dec_ratio < R_MIN) begin
                        r_d = R_MIN;
                    end else if (dec_ratio > R_MAX) begin
                        r_d = R_MAX;
                    end else begin
                        r_d = dec_ratio;
                    end
                    cnt_d  = '0;
                    wcnt_d = '0;
                    for (int k = 0; k < ORDER; k++) begin
                        integ_d[k] = '0;
                        dly_d[k]   = '0;
                    end
                end
            end
            S_WARMUP, S_RUN: begin
                if (!en) begin
                    // Abort beats a coincident tick: no output this cycle
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                    for (int k = 0; k < ORDER; k++) begin
                        integ_d[k] = '0;
                        dly_d[k]   = '0;
                    end
                end else begin
                    // Pipelined integrators: each stage adds the previous stage's old value
                    integ_d[0] = integ_q[0] + ACC_W'(din);
                    for (int k = 1; k < ORDER; k++) begin
                        integ_d[k] = integ_q[k] + integ_q[k-1];
                    end
                    cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
                    if (tick_c) begin
                        for (int k = 0; k < ORDER; k++) begin
                            dly_d[k] = comb_c[k];
                        end
                        if (state_q == S_RUN) begin
                            dout_d       = OUT_W'(comb_c[ORDER]);
                            dout_valid_d = 1'b1;
                        end else if (wcnt_q == WCNT_W'(ORDER - 1)) begin
                            state_d = S_RUN;
                            wcnt_d  = '0;
                        end else begin
                            wcnt_d = wcnt_q + WCNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        running_d = (state_d != S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            r_q          <= R_MIN;
            cnt_q        <= '0;
            wcnt_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            running_q    <= 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            cnt_q        <= cnt_d;
            wcnt_q       <= wcnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            running_q    <= running_d;
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= integ_d[k];
                dly_q[k]   <= dly_d[k];
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: directed + random bench for cic_decimator (ORDER=2, RMAX_LOG2=8).
// The reference treats each output as a triangular-weighted count of ones over
// the two windows preceding the tick (the impulse response of a 2nd-order CIC).
module tb_cic_decimator;

    localparam int unsigned ORDER     = 2;
    localparam int unsigned RMAX_LOG2 = 8;
    localparam int unsigned OUT_W     = 32;
    localparam int          HIST_N    = 16384;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [RMAX_LOG2:0]   dec_ratio;
    logic                 din;
    logic [OUT_W-1:0]     dout;
    logic                 dout_valid;
    logic                 running;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    // Reference model state
    bit          m_active;
    bit          m_valid;
    int          m_c;
    int          m_r;
    longint      m_hold;
    bit          hist [HIST_N];
    longint      exp_q [$];

    cic_decimator #(
        .ORDER     (ORDER),
        .RMAX_LOG2 (RMAX_LOG2),
        .OUT_W     (OUT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dec_ratio  (dec_ratio),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .running    (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Triangular-weighted window count for a tick in cycle c with ratio r
    function automatic longint tri_sum(input int c, input int r);
        longint s = 0;
        for (int d = 1; d < 2 * r; d++) begin
            int w = (d <= r) ? d : 2 * r - d;
            if (hist[c - 1 - d]) s += longint'(w);
        end
        return s;
    endfunction

    // Reference model, advanced on every active edge
    always @(posedge clk) begin
        m_valid = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_hold   = 0;
            exp_q.delete();
        end else if (!m_active) begin
            if (en) begin
                m_active = 1'b1;
                m_c      = 0;
                m_r      = (int'(dec_ratio) < 2) ? 2 :
                           (int'(dec_ratio) > 256) ? 256 : int'(dec_ratio);
            end
        end else if (!en) begin
            m_active = 1'b0;
        end else begin
            if (m_c < HIST_N) hist[m_c] = din;
            if (((m_c + 1) % m_r == 0) && (m_c + 1 >= (ORDER + 1) * m_r) && (m_c < HIST_N)) begin
                m_hold  = tri_sum(m_c, m_r);
                m_valid = 1'b1;
                exp_q.push_back(m_hold);
            end
            m_c++;
        end
    end

    // Scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("dout_valid", 64'(dout_valid), 64'(m_valid));
            check("running", 64'(running), 64'(m_active));
            if (dout_valid === 1'b1) begin
                check("sb_depth", 64'(exp_q.size()), 64'd1);
                if (exp_q.size() != 0) begin
                    check("dout_strobe", 64'(dout), 64'(exp_q.pop_front()));
                end
            end
            check("dout_hold", 64'(dout), 64'(m_hold));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_strobes(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dout_valid === 1'b1) cnt++;
        end
    endtask

    initial begin
        int n;
        int cnt;

        rst       = 1'b1;
        en        = 1'b0;
        din       = 1'b0;
        dec_ratio = 9'd16;

        // Reset for two edges, then idle with en low
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_on = 1'b1;
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_running", 64'(running), 64'd0);
        rst = 1'b0;
        count_strobes(50, cnt);
        check("idle_no_strobe", 64'(cnt), 64'd0);

        // R=16, all ones: first strobe latency and full-scale value
        din = 1'b1;
        en  = 1'b1;
        n   = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (dout_valid === 1'b1) begin
                n = i;
                break;
            end
        end
        check("first_strobe_latency", 64'(n), 64'd49);
        count_strobes(64, cnt);
        check("r16_strobe_count", 64'(cnt), 64'd4);
        check("r16_full_scale", 64'(dout), 64'd256);

        // R=16, alternating din
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 16 * 6; i++) begin
            din = ~din;
            @(negedge clk);
        end
        check("r16_alternating", 64'(dout), 64'd128);

        // R=16, all zeros
        en = 1'b0;
        din = 1'b0;
        @(negedge clk);
        en = 1'b1;
        cycles(16 * 5);
        check("r16_zeros", 64'(dout), 64'd0);

        // dec_ratio=0 clamps to 2
        en = 1'b0;
        dec_ratio = 9'd0;
        din = 1'b1;
        @(negedge clk);
        en = 1'b1;
        cycles(12);
        count_strobes(20, cnt);
        check("r2_strobe_count", 64'(cnt), 64'd10);
        check("r2_full_scale", 64'(dout), 64'd4);

        // dec_ratio=511 clamps to 256
        en = 1'b0;
        dec_ratio = 9'd511;
        @(negedge clk);
        en = 1'b1;
        cycles(256 * 4 + 2);
        check("r256_full_scale", 64'(dout), 64'd65536);

        // One-cycle en drop mid-RUN, then a ratio change that must be ignored
        en = 1'b0;
        dec_ratio = 9'd16;
        @(negedge clk);
        en = 1'b1;
        cycles(16 * 5);
        en = 1'b0;
        @(negedge clk);
        check("gap_hold", 64'(dout), 64'd256);
        en = 1'b1;
        count_strobes(16 * 3, cnt);
        check("rewarm_no_strobe", 64'(cnt), 64'd0);
        dec_ratio = 9'd4;
        cycles(8);
        count_strobes(64, cnt);
        check("ratio_change_ignored", 64'(cnt), 64'd4);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        cycles(4 * 3 + 4);
        count_strobes(32, cnt);
        check("ratio_applied_after_toggle", 64'(cnt), 64'd8);
        check("r4_full_scale", 64'(dout), 64'd16);

        // Random bitstream at R=256 with wrapping integrators, then mid-window reset
        en = 1'b0;
        dec_ratio = 9'd256;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            din = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_dout", 64'(dout), 64'd0);
        check("midrst_valid", 64'(dout_valid), 64'd0);
        check("midrst_running", 64'(running), 64'd0);
        rst = 1'b0;
        en  = 1'b0;
        cycles(4);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
